// File: rtl/exec_iter_muldiv_if.sv
// rtl/exec_iter_muldiv_if.sv - issue/result bundle for the iterative multiply/divide unit
interface exec_iter_muldiv_if #(
  parameter int W_OPR   = 32,
  parameter int W_RD    = 5,
  parameter int W_FLAGS = 4
);
  logic               v_i;
  logic [1:0]         op_i;
  logic               signed_i;
  logic [W_OPR-1:0]   opr0_i;
  logic [W_OPR-1:0]   opr1_i;
  logic               wb_i;
  logic [W_RD-1:0]    wb_r_i;
  logic               kill_i;
  logic               stall_i;
  logic               stall_o;
  logic               v_o;
  logic [W_OPR-1:0]   result_o;
  logic [W_FLAGS-1:0] flags_o;
  logic               wb_o;
  logic [W_RD-1:0]    wb_r_o;

  modport master (
    output v_i, op_i, signed_i, opr0_i, opr1_i, wb_i, wb_r_i, kill_i, stall_i,
    input  stall_o, v_o, result_o, flags_o, wb_o, wb_r_o
  );

  modport slave (
    input  v_i, op_i, signed_i, opr0_i, opr1_i, wb_i, wb_r_i, kill_i, stall_i,
    output stall_o, v_o, result_o, flags_o, wb_o, wb_r_o
  );
endinterface

// File: rtl/exec_iter_muldiv.sv
// rtl/exec_iter_muldiv.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module exec_iter_muldiv #(
  parameter int W_OPR   = 32,
  parameter int W_RD    = 5,
  parameter int W_FLAGS = 4
) (
  input  logic                clk,
  input  logic                reset,
  exec_iter_muldiv_if.slave   bus
);
  localparam int W_CNT = (W_OPR > 1) ? $clog2(W_OPR) : 1;
  localparam logic [W_CNT-1:0] LAST_ITER = W_CNT'(W_OPR - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic               sgn_q;
  logic               wb_q;
  logic [W_RD-1:0]    wb_r_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               ovf_q;
  logic [W_OPR-1:0]   b_q;
  logic [2*W_OPR-1:0] acc_q;
  logic [W_CNT-1:0]   cnt_q;
  logic [W_OPR-1:0]   res_q;
  logic [W_FLAGS-1:0] flags_q;

  logic               neg0, neg1, div0, min_m1, accept;
  logic [W_OPR-1:0]   mag0, mag1;

  assign neg0   = bus.signed_i & bus.opr0_i[W_OPR-1];
  assign neg1   = bus.signed_i & bus.opr1_i[W_OPR-1];
  assign mag0   = neg0 ? -bus.opr0_i : bus.opr0_i;
  assign mag1   = neg1 ? -bus.opr1_i : bus.opr1_i;
  assign div0   = (bus.opr1_i == '0);
  assign min_m1 = bus.signed_i & (bus.opr0_i == {1'b1, {(W_OPR-1){1'b0}}}) & (&bus.opr1_i);
  assign accept = (state == S_IDLE) & bus.v_i & ~bus.kill_i;

  // acc holds {product_hi, multiplier} for MUL and {remainder, quotient} for DIV
  logic [W_OPR:0]     mul_add, div_shl, div_diff;
  logic               div_ge;
  logic [W_OPR-1:0]   rem_nx;
  logic [2*W_OPR-1:0] acc_nx, prod_s;
  logic [W_OPR-1:0]   quo_s, rem_s, res_nx;
  logic               carry_nx;

  always_comb begin
    mul_add  = {1'b0, acc_q[2*W_OPR-1:W_OPR]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shl  = {acc_q[2*W_OPR-1:W_OPR], acc_q[W_OPR-1]};
    div_diff = div_shl - {1'b0, b_q};
    div_ge   = ~div_diff[W_OPR];
    rem_nx   = div_ge ? div_diff[W_OPR-1:0] : div_shl[W_OPR-1:0];
    acc_nx   = op_q[1] ? {rem_nx, acc_q[W_OPR-2:0], div_ge}
                       : {mul_add, acc_q[W_OPR-1:1]};
    prod_s   = neg_res_q ? -acc_nx : acc_nx;
    quo_s    = neg_res_q ? -acc_nx[W_OPR-1:0] : acc_nx[W_OPR-1:0];
    rem_s    = neg_rem_q ? -acc_nx[2*W_OPR-1:W_OPR] : acc_nx[2*W_OPR-1:W_OPR];
    case (op_q)
      2'b00:   res_nx = prod_s[W_OPR-1:0];
      2'b01:   res_nx = prod_s[2*W_OPR-1:W_OPR];
      2'b10:   res_nx = quo_s;
      default: res_nx = rem_s;
    endcase
    if (op_q[1])
      carry_nx = 1'b0;
    else if (sgn_q)
      carry_nx = prod_s[2*W_OPR-1:W_OPR] != {W_OPR{prod_s[W_OPR-1]}};
    else
      carry_nx = prod_s[2*W_OPR-1:W_OPR] != '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      wb_q      <= 1'b0;
      wb_r_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= bus.op_i;
            sgn_q     <= bus.signed_i;
            wb_q      <= bus.wb_i;
            wb_r_q    <= bus.wb_r_i;
            // a zero divisor keeps the all-ones quotient uncorrected
            neg_res_q <= (neg0 ^ neg1) & ~(bus.op_i[1] & div0);
            neg_rem_q <= neg0;
            ovf_q     <= bus.op_i[1] & (div0 | min_m1);
            b_q       <= mag1;
            acc_q     <= {{W_OPR{1'b0}}, mag0};
            cnt_q     <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.kill_i) begin
            state <= S_IDLE;
          end else begin
            acc_q <= acc_nx;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              res_q   <= res_nx;
              flags_q <= W_FLAGS'({ovf_q, res_nx[W_OPR-1], res_nx == '0, carry_nx});
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.kill_i || !bus.stall_i)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o  = accept | (state == S_BUSY) | ((state == S_DONE) & bus.stall_i);
  assign bus.v_o      = (state == S_DONE);
  assign bus.result_o = res_q;
  assign bus.flags_o  = flags_q;
  assign bus.wb_o     = wb_q & (state == S_DONE);
  assign bus.wb_r_o   = wb_r_q;
endmodule

// File: tb/tb_exec_iter_muldiv.sv
// tb/tb_exec_iter_muldiv.sv - directed self-checking bench for exec_iter_muldiv at W_OPR=8
module tb_exec_iter_muldiv;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  exec_iter_muldiv_if #(.W_OPR(W), .W_RD(5), .W_FLAGS(4)) bus ();

  exec_iter_muldiv #(.W_OPR(W), .W_RD(5), .W_FLAGS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] op;
    logic       sg;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.v_i = 1'b0; bus.op_i = 2'b00; bus.signed_i = 1'b0;
    bus.opr0_i = '0; bus.opr1_i = '0; bus.wb_i = 1'b0; bus.wb_r_i = '0;
    bus.kill_i = 1'b0; bus.stall_i = 1'b0;
  endtask

  // Issues one op and returns once v_o rises (or the cycle bound expires); leaves the unit in DONE.
  task automatic run_op(input logic [1:0] op, input logic sg, input logic [7:0] a, input logic [7:0] b,
                        input logic wb, input logic [4:0] wbr,
                        output logic [7:0] res, output logic [3:0] flg, output logic wbo,
                        output logic [4:0] wbro, output int lat, output logic stall_ok);
    bus.v_i = 1'b1; bus.op_i = op; bus.signed_i = sg; bus.opr0_i = a; bus.opr1_i = b;
    bus.wb_i = wb; bus.wb_r_i = wbr;
    #1;
    stall_ok = bus.stall_o;
    step;
    bus.v_i = 1'b0;
    lat = 0;
    while (!bus.v_o && lat < 40) begin
      if (!bus.stall_o) stall_ok = 1'b0;
      step;
      lat++;
    end
    res = bus.result_o; flg = bus.flags_o; wbo = bus.wb_o; wbro = bus.wb_r_o;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    #2;
    checks++;
    if (bus.v_o !== 1'b0 || bus.wb_o !== 1'b0 || bus.result_o !== 8'h00 ||
        bus.flags_o !== 4'h0 || bus.wb_r_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b wb=%b res=%h flg=%b wbr=%0d want all zero",
               bus.v_o, bus.wb_o, bus.result_o, bus.flags_o, bus.wb_r_o);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall_idle: got %b want 0", bus.stall_o);
    end
    bus.v_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL reset_stall_vi: got %b want 1", bus.stall_o);
    end
    bus.v_i = 1'b0;
    step;
    reset = 1'b0;
    step;
  endtask

  task automatic test_mul_basic;
    logic [7:0] res; logic [3:0] flg; logic wbo; logic [4:0] wbro; int lat; logic stall_ok;
    run_op(2'b00, 1'b0, 8'h0F, 8'h11, 1'b1, 5'd3, res, flg, wbo, wbro, lat, stall_ok);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL mul_latency: got %0d want 8", lat); end
    checks++;
    if (res !== 8'hFF || flg !== 4'b0100) begin
      errors++; $display("FAIL mul_result: got %h/%b want ff/0100", res, flg);
    end
    checks++;
    if (wbo !== 1'b1 || wbro !== 5'd3) begin
      errors++; $display("FAIL mul_wb: got wb=%b wbr=%0d want 1/3", wbo, wbro);
    end
    checks++;
    if (stall_ok !== 1'b1) begin
      errors++; $display("FAIL mul_stall_busy: got %b want 1", stall_ok);
    end
    step;
    checks++;
    if (bus.v_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL mul_exit: got v=%b stall=%b want 0/0", bus.v_o, bus.stall_o);
    end
  endtask

  task automatic check_vectors(input string name, input vec_t vecs[4]);
    logic [7:0] res; logic [3:0] flg; logic wbo; logic [4:0] wbro; int lat; logic stall_ok;
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, 1'b0, 5'd9, res, flg, wbo, wbro, lat, stall_ok);
      checks++;
      if (res !== vecs[i].res || flg !== vecs[i].flg || lat !== 8 || wbo !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d]: got res=%h flg=%b lat=%0d wb=%b want res=%h flg=%b lat=8 wb=0",
                 name, i, res, flg, lat, wbo, vecs[i].res, vecs[i].flg);
      end
      step;
    end
  endtask

  task automatic test_mulh;
    vec_t v[4];
    v[0] = '{2'b01, 1'b0, 8'hFF, 8'hFF, 8'hFE, 4'b0101};
    v[1] = '{2'b00, 1'b0, 8'hFF, 8'hFF, 8'h01, 4'b0001};
    v[2] = '{2'b01, 1'b1, 8'hFD, 8'h05, 8'hFF, 4'b0100};
    v[3] = '{2'b00, 1'b1, 8'hF0, 8'h10, 8'h00, 4'b0011};
    check_vectors("mul_vec", v);
  endtask

  task automatic test_div;
    vec_t v[4];
    v[0] = '{2'b10, 1'b1, 8'hF9, 8'h02, 8'hFD, 4'b0100};
    v[1] = '{2'b11, 1'b1, 8'hF9, 8'h02, 8'hFF, 4'b0100};
    v[2] = '{2'b10, 1'b0, 8'h64, 8'h07, 8'h0E, 4'b0000};
    v[3] = '{2'b11, 1'b0, 8'h64, 8'h07, 8'h02, 4'b0000};
    check_vectors("div_vec", v);
  endtask

  task automatic test_div_special;
    vec_t v[4];
    v[0] = '{2'b10, 1'b0, 8'h2A, 8'h00, 8'hFF, 4'b1100};
    v[1] = '{2'b11, 1'b0, 8'h2A, 8'h00, 8'h2A, 4'b1000};
    v[2] = '{2'b10, 1'b1, 8'h80, 8'hFF, 8'h80, 4'b1100};
    v[3] = '{2'b11, 1'b1, 8'h80, 8'hFF, 8'h00, 4'b1010};
    check_vectors("div_special", v);
  endtask

  task automatic test_stall;
    logic [7:0] res; logic [3:0] flg; logic wbo; logic [4:0] wbro; int lat; logic stall_ok;
    int bad;
    run_op(2'b00, 1'b0, 8'h03, 8'h04, 1'b1, 5'd5, res, flg, wbo, wbro, lat, stall_ok);
    bus.stall_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (bus.v_o !== 1'b1 || bus.result_o !== 8'h0C || bus.flags_o !== 4'b0000 ||
          bus.stall_o !== 1'b1 || bus.wb_o !== 1'b1 || bus.wb_r_o !== 5'd5) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
    bus.stall_i = 1'b0;
    step;
    checks++;
    if (bus.v_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL stall_release: got v=%b stall=%b want 0/0", bus.v_o, bus.stall_o);
    end
  endtask

  task automatic test_kill;
    logic [7:0] res; logic [3:0] flg; logic wbo; logic [4:0] wbro; int lat; logic stall_ok;
    int seen;
    bus.v_i = 1'b1; bus.op_i = 2'b00; bus.signed_i = 1'b0; bus.opr0_i = 8'hFF; bus.opr1_i = 8'hFF;
    step;
    bus.v_i = 1'b0;
    for (int i = 0; i < 4; i++) step;
    bus.kill_i = 1'b1;
    step;
    bus.kill_i = 1'b0;
    #1;
    checks++;
    if (bus.v_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL kill_abort: got v=%b stall=%b want 0/0", bus.v_o, bus.stall_o);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin step; if (bus.v_o !== 1'b0) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL kill_no_valid: got %0d valid cycles want 0", seen); end
    run_op(2'b00, 1'b0, 8'h03, 8'h04, 1'b1, 5'd7, res, flg, wbo, wbro, lat, stall_ok);
    checks++;
    if (res !== 8'h0C || flg !== 4'b0000 || lat !== 8) begin
      errors++; $display("FAIL kill_next_mul: got res=%h flg=%b lat=%0d want 0c/0000/8", res, flg, lat);
    end
    step;
  endtask

  task automatic test_reset_mid;
    int seen;
    bus.v_i = 1'b1; bus.op_i = 2'b00; bus.signed_i = 1'b0; bus.opr0_i = 8'h05; bus.opr1_i = 8'h06;
    bus.wb_i = 1'b1; bus.wb_r_i = 5'd12;
    step;
    bus.v_i = 1'b0;
    step;
    step;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.v_o !== 1'b0 || bus.wb_o !== 1'b0 || bus.result_o !== 8'h00 || bus.flags_o !== 4'h0 ||
        bus.wb_r_o !== 5'd0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b wb=%b res=%h flg=%b wbr=%0d stall=%b want all zero",
               bus.v_o, bus.wb_o, bus.result_o, bus.flags_o, bus.wb_r_o, bus.stall_o);
    end
    step;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin step; if (bus.v_o !== 1'b0) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_valid: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mulh();
    test_div();
    test_div_special();
    test_stall();
    test_kill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
